mem_responder: RTL

//  Memory-side responder for the CPU bus: serves CPU fetch/read/write requests with req/ready timing.

---
 rtl/mem_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Memory-side CPU responder: boot-loaded 8-bit store with WAIT_CYCLES wait states per access.
// Optional ROM_PROTECT_EN: CPU writes below PROT_LIMIT are dropped and flagged on wr_err.
module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int LOAD_LEN    = 256,
    parameter int PROT_LIMIT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic [7:0] cpu_addr,
    input  logic       cpu_readwrite,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ready,
    output logic       cpu_hold,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    output logic       boot_done,
    output logic       wr_err
);
    typedef enum logic [1:0] {BOOT, IDLE, WAIT, RESP} state_t;

    state_t     state_q;
    logic [8:0] ld_ptr_q;
    logic [3:0] cnt_q;
    logic [7:0] addr_q, wdata_q, rdata_q;
    logic       we_q, ready_q, hold_q, ld_ready_q, boot_done_q, wr_err_q;
    logic [7:0] mem [DEPTH];

    logic       ld_acc_d, in_range_d, prot_d, mem_wr_d;
    logic [7:0] rd_d;

    assign ld_acc_d   = (state_q == BOOT) && ld_valid && ld_ready_q;
    assign in_range_d = {1'b0, addr_q} < 9'(DEPTH);
`ifdef ROM_PROTECT_EN
    assign prot_d     = {1'b0, addr_q} < 9'(PROT_LIMIT);
`else
    logic unused_prot;
    assign unused_prot = PROT_LIMIT[0];
    assign prot_d      = 1'b0;
`endif
    assign mem_wr_d   = (state_q == RESP) && we_q && in_range_d && !prot_d;
    assign rd_d       = in_range_d ? mem[addr_q] : 8'h00;

    // Contents survive reset; only a live reset cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (ld_acc_d)
                mem[ld_ptr_q[7:0]] <= ld_data;
            else if (mem_wr_d)
                mem[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            ld_ptr_q    <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rdata_q     <= 8'h00;
            ready_q     <= 1'b0;
            hold_q      <= 1'b1;
            ld_ready_q  <= 1'b1;
            boot_done_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            ready_q  <= 1'b0;
            wr_err_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    if (ld_acc_d) begin
                        ld_ptr_q <= ld_ptr_q + 9'd1;
                        if (ld_last || ld_ptr_q == 9'(LOAD_LEN - 1)) begin
                            state_q     <= IDLE;
                            ld_ready_q  <= 1'b0;
                            hold_q      <= 1'b0;
                            boot_done_q <= 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_readwrite;
                        wdata_q <= cpu_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                        end else begin
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) state_q <= RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                RESP: begin
                    ready_q <= 1'b1;
                    if (!we_q) rdata_q  <= rd_d;
                    else       wr_err_q <= prot_d;
                    state_q <= IDLE;
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign cpu_hold  = hold_q;
    assign ld_ready  = ld_ready_q;
    assign boot_done = boot_done_q;
    assign wr_err    = wr_err_q;
endmodule
